// File: rtl/apb_decode_bridge.sv
`default_nettype none
// ============================================================================
// Module      : apb_decode_bridge
// Description : Registered single-clock APB bridge with a 1-to-NSLAVES
//               address decoder. Every signal is flopped in both directions.
//               Unmapped slave indices complete at once with PSLVERROR.
//               Optional feature macro: APB_TIMEOUT_EN (forced error response
//               when a selected slave stays not-ready for TIMEOUT_CYCLES).
// Revision    : 1.0 - initial release
// ============================================================================
module apb_decode_bridge #(
   parameter int AWIDTH         = 12,
   parameter int NSLAVES        = 4,
   parameter int SEL_LSB        = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    reset,
   // upstream (master side)
   input  logic [AWIDTH-1:0]       input_PADDR,
   input  logic                    input_PSEL,
   input  logic                    input_PENABLE,
   input  logic                    input_PWRITE,
   input  logic [31:0]             input_PWDATA,
   output logic                    input_PREADY,
   output logic [31:0]             input_PRDATA,
   output logic                    input_PSLVERROR,
   // downstream (slave side)
   output logic [AWIDTH-1:0]       output_PADDR,
   output logic [NSLAVES-1:0]      output_PSEL,
   output logic                    output_PENABLE,
   output logic                    output_PWRITE,
   output logic [31:0]             output_PWDATA,
   input  logic [NSLAVES-1:0]      output_PREADY,
   input  logic [32*NSLAVES-1:0]   output_PRDATA,
   input  logic [NSLAVES-1:0]      output_PSLVERROR
);

   localparam int SEL_W = $clog2(NSLAVES);
   // slave count widened by one bit so the decode compare is width-matched
   localparam logic [SEL_W:0] c_NSL_EXT = (SEL_W+1)'(NSLAVES);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t               r_state;
   logic [SEL_W-1:0]     r_idx;
   // set once PENABLE has been seen low; a transfer is only accepted while set,
   // so a master still holding PENABLE after the response cannot re-trigger
   logic                 r_rearm;

   logic [SEL_W-1:0]     w_idx;
   logic                 w_hit;
   logic                 w_accept;
   logic [NSLAVES-1:0]   w_psel_dec;
   logic                 w_sel_ready;
   logic [31:0]          w_sel_rdata;
   logic                 w_sel_err;

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES+1);
   // counter value in the ACCESS cycle that expires the transfer
   localparam logic [CNT_W-1:0] c_TMO_LAST = CNT_W'(TIMEOUT_CYCLES-1);
   logic [CNT_W-1:0]     r_tmo_cnt;
`endif

   assign w_idx    = input_PADDR[SEL_LSB +: SEL_W];
   assign w_hit    = ({1'b0, w_idx} < c_NSL_EXT);
   assign w_accept = (r_state == S_IDLE) & input_PSEL & input_PENABLE & r_rearm;

   // one-hot decode of the incoming slave index
   always_comb begin
      w_psel_dec = '0;
      for (int i = 0; i < NSLAVES; i++) begin
         if (w_idx == SEL_W'(i)) begin
            w_psel_dec[i] = 1'b1;
         end
      end
   end

   // response mux: only the slave latched in r_idx is observed
   always_comb begin
      w_sel_ready = 1'b0;
      w_sel_rdata = '0;
      w_sel_err   = 1'b0;
      for (int i = 0; i < NSLAVES; i++) begin
         if (r_idx == SEL_W'(i)) begin
            w_sel_ready = output_PREADY[i];
            w_sel_rdata = output_PRDATA[32*i +: 32];
            w_sel_err   = output_PSLVERROR[i];
         end
      end
   end

   // transfer sequencer; all ports are driven straight from these flops
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= S_IDLE;
         r_idx           <= '0;
         r_rearm         <= 1'b1;
         input_PREADY    <= 1'b0;
         input_PRDATA    <= '0;
         input_PSLVERROR <= 1'b0;
         output_PADDR    <= '0;
         output_PSEL     <= '0;
         output_PENABLE  <= 1'b0;
         output_PWRITE   <= 1'b0;
         output_PWDATA   <= '0;
`ifdef APB_TIMEOUT_EN
         r_tmo_cnt       <= '0;
`endif
      end else begin
         input_PREADY <= 1'b0;

         if (w_accept) begin
            r_rearm <= 1'b0;
         end else if (!input_PENABLE) begin
            r_rearm <= 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  output_PADDR  <= input_PADDR;
                  output_PWRITE <= input_PWRITE;
                  output_PWDATA <= input_PWDATA;
                  r_idx         <= w_idx;
                  if (w_hit) begin
                     output_PSEL    <= w_psel_dec;
                     output_PENABLE <= 1'b0;
                     r_state        <= S_SETUP;
                  end else begin
                     // unmapped index: answer immediately, nothing goes downstream
                     input_PREADY    <= 1'b1;
                     input_PRDATA    <= '0;
                     input_PSLVERROR <= 1'b1;
                     r_state         <= S_RESP;
                  end
               end
            end

            S_SETUP: begin
               output_PENABLE <= 1'b1;
               r_state        <= S_ACCESS;
`ifdef APB_TIMEOUT_EN
               r_tmo_cnt      <= '0;
`endif
            end

            S_ACCESS: begin
               if (w_sel_ready) begin
                  input_PRDATA    <= w_sel_rdata;
                  input_PSLVERROR <= w_sel_err;
                  input_PREADY    <= 1'b1;
                  output_PSEL     <= '0;
                  output_PENABLE  <= 1'b0;
                  r_state         <= S_RESP;
               end
`ifdef APB_TIMEOUT_EN
               else if (r_tmo_cnt == c_TMO_LAST) begin
                  // slave never answered: abandon it and report an error
                  input_PRDATA    <= '0;
                  input_PSLVERROR <= 1'b1;
                  input_PREADY    <= 1'b1;
                  output_PSEL     <= '0;
                  output_PENABLE  <= 1'b0;
                  r_state         <= S_RESP;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 1'b1;
               end
`endif
            end

            S_RESP: begin
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_apb_decode_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_decode_bridge
// Description : Directed self-checking bench for apb_decode_bridge (default
//               build, APB_TIMEOUT_EN undefined). A 4-slave instance carries
//               the main traffic; a 3-slave instance shares the master bus
//               to exercise the unmapped-index path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_decode_bridge;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic [11:0]  m_paddr;
   logic         m_psel, m_penable, m_pwrite;
   logic [31:0]  m_pwdata;

   // 4-slave instance
   logic         m_pready, m_perr;
   logic [31:0]  m_prdata;
   logic [11:0]  d_paddr;
   logic [3:0]   d_psel;
   logic         d_penable, d_pwrite;
   logic [31:0]  d_pwdata;
   logic [3:0]   s_pready, s_perr;
   logic [127:0] s_prdata;

   // 3-slave instance
   logic         m3_pready, m3_perr;
   logic [31:0]  m3_prdata;
   logic [11:0]  d3_paddr;
   logic [2:0]   d3_psel;
   logic         d3_penable, d3_pwrite;
   logic [31:0]  d3_pwdata;
   logic [2:0]   s3_pready = 3'b111;
   logic [2:0]   s3_perr   = 3'b000;
   logic [95:0]  s3_prdata = '0;

   apb_decode_bridge #(.AWIDTH(12), .NSLAVES(4), .SEL_LSB(8), .TIMEOUT_CYCLES(8)) u_dut4 (
      .clk(clk), .reset(reset),
      .input_PADDR(m_paddr), .input_PSEL(m_psel), .input_PENABLE(m_penable),
      .input_PWRITE(m_pwrite), .input_PWDATA(m_pwdata),
      .input_PREADY(m_pready), .input_PRDATA(m_prdata), .input_PSLVERROR(m_perr),
      .output_PADDR(d_paddr), .output_PSEL(d_psel), .output_PENABLE(d_penable),
      .output_PWRITE(d_pwrite), .output_PWDATA(d_pwdata),
      .output_PREADY(s_pready), .output_PRDATA(s_prdata), .output_PSLVERROR(s_perr)
   );

   apb_decode_bridge #(.AWIDTH(12), .NSLAVES(3), .SEL_LSB(8), .TIMEOUT_CYCLES(8)) u_dut3 (
      .clk(clk), .reset(reset),
      .input_PADDR(m_paddr), .input_PSEL(m_psel), .input_PENABLE(m_penable),
      .input_PWRITE(m_pwrite), .input_PWDATA(m_pwdata),
      .input_PREADY(m3_pready), .input_PRDATA(m3_prdata), .input_PSLVERROR(m3_perr),
      .output_PADDR(d3_paddr), .output_PSEL(d3_psel), .output_PENABLE(d3_penable),
      .output_PWRITE(d3_pwrite), .output_PWDATA(d3_pwdata),
      .output_PREADY(s3_pready), .output_PRDATA(s3_prdata), .output_PSLVERROR(s3_perr)
   );

   // slave models: each ready after wait_cfg[i] ACCESS cycles, unless hung
   int          wait_cfg [4];
   logic [31:0] rd_cfg   [4];
   logic        err_cfg  [4];
   logic        hang;
   int          wcnt;

   always_comb begin
      s_pready = '0;
      s_prdata = '0;
      s_perr   = '0;
      for (int i = 0; i < 4; i++) begin
         s_pready[i]         = d_psel[i] & d_penable & ~hang & (wcnt >= wait_cfg[i]);
         s_prdata[32*i +: 32] = rd_cfg[i];
         s_perr[i]           = err_cfg[i];
      end
   end

   always @(posedge clk) begin
      if (reset || !(d_penable && (|d_psel)) || (|(s_pready & d_psel)))
         wcnt <= 0;
      else
         wcnt <= wcnt + 1;
   end

   int n_pulse = 0;
   always @(negedge clk) if (m_pready === 1'b1) n_pulse++;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] tr_psel [1:8];
   logic       tr_pen  [1:8];

   // full APB transfer on the shared master bus, timed against u_dut4
   task automatic xfer(input logic [11:0] a, input logic w, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output logic e);
      m_paddr = a; m_pwrite = w; m_pwdata = wd;
      m_psel = 1'b1; m_penable = 1'b0;
      tick();
      m_penable = 1'b1;
      lat = -1; rd = '0; e = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         tick();
         if (n <= 8) begin
            tr_psel[n] = d_psel;
            tr_pen[n]  = d_penable;
         end
         if (d_penable) begin
            chk("access_paddr_stable",  d_paddr,  a);
            chk("access_pwdata_stable", d_pwdata, wd);
            chk("access_pwrite_stable", d_pwrite, w);
         end
         if (m_pready) begin
            lat = n; rd = m_prdata; e = m_perr;
            break;
         end
      end
      m_psel = 1'b0; m_penable = 1'b0;
      tick();
   endtask

   int          lat;
   logic [31:0] rd;
   logic        e;
   int          p0;

   initial begin
      for (int i = 0; i < 4; i++) begin
         wait_cfg[i] = 0;
         rd_cfg[i]   = 32'hCAFE0000 + 32'(i);
         err_cfg[i]  = 1'b0;
      end
      wait_cfg[0] = 3;
      err_cfg[1]  = 1'b1;
      hang = 1'b0;
      m_paddr = '0; m_psel = 1'b0; m_penable = 1'b0; m_pwrite = 1'b0; m_pwdata = '0;
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      tick();

      // reset state
      chk("rst_pready",  m_pready,  1'b0);
      chk("rst_prdata",  m_prdata,  32'h0);
      chk("rst_perr",    m_perr,    1'b0);
      chk("rst_psel",    d_psel,    4'h0);
      chk("rst_penable", d_penable, 1'b0);
      chk("rst_paddr",   d_paddr,   12'h0);

      // read slave 2, zero wait
      xfer(12'h2A4, 1'b0, 32'h0, lat, rd, e);
      chk("rd2_psel_t1",   tr_psel[1], 4'b0100);
      chk("rd2_pen_t1",    tr_pen[1],  1'b0);
      chk("rd2_psel_t2",   tr_psel[2], 4'b0100);
      chk("rd2_pen_t2",    tr_pen[2],  1'b1);
      chk("rd2_latency",   64'(lat),   64'd3);
      chk("rd2_prdata",    rd,         32'hCAFE0002);
      chk("rd2_perr",      e,          1'b0);
      chk("rd2_pulse_end", m_pready,   1'b0);

      // write slave 0, three wait states
      xfer(12'h010, 1'b1, 32'h12345678, lat, rd, e);
      chk("wr0_latency", 64'(lat), 64'd6);
      chk("wr0_perr",    e,        1'b0);
      chk("wr0_psel_t1", tr_psel[1], 4'b0001);

      // unmapped index on the 3-slave instance
      m_paddr = 12'h3A0; m_pwrite = 1'b0; m_pwdata = 32'h0;
      m_psel = 1'b1; m_penable = 1'b0;
      tick();
      m_penable = 1'b1;
      tick();
      chk("miss_pready_t1", m3_pready, 1'b1);
      chk("miss_perr",      m3_perr,   1'b1);
      chk("miss_prdata",    m3_prdata, 32'h0);
      chk("miss_psel",      d3_psel,   3'b000);
      m_psel = 1'b0; m_penable = 1'b0;
      tick();
      chk("miss_pulse_len", m3_pready, 1'b0);
      chk("miss_psel_t2",   d3_psel,   3'b000);
      tick(); tick(); tick(); tick();

      // slave 1 error response
      xfer(12'h1C0, 1'b0, 32'h0, lat, rd, e);
      chk("err1_latency", 64'(lat), 64'd3);
      chk("err1_perr",    e,        1'b1);
      chk("err1_prdata",  rd,       32'hCAFE0001);

      // hung slave with no timeout: bridge stays in ACCESS
      hang = 1'b1;
      p0 = n_pulse;
      m_paddr = 12'h0F0; m_pwrite = 1'b1; m_pwdata = 32'hA5A5A5A5;
      m_psel = 1'b1; m_penable = 1'b0;
      tick();
      m_penable = 1'b1;
      for (int n = 0; n < 20; n++) tick();
      chk("hang_psel",    d_psel,    4'b0001);
      chk("hang_penable", d_penable, 1'b1);
      chk("hang_nopulse", 64'(n_pulse - p0), 64'd0);

      // reset during ACCESS abandons the transfer
      reset = 1'b1;
      tick();
      chk("midrst_psel",    d_psel,    4'h0);
      chk("midrst_penable", d_penable, 1'b0);
      chk("midrst_pready",  m_pready,  1'b0);
      chk("midrst_paddr",   d_paddr,   12'h0);
      chk("midrst_pwdata",  d_pwdata,  32'h0);
      chk("midrst_pwrite",  d_pwrite,  1'b0);
      reset = 1'b0; hang = 1'b0;
      m_psel = 1'b0; m_penable = 1'b0;
      tick(); tick(); tick();
      chk("midrst_nopulse", 64'(n_pulse - p0), 64'd0);

      // normal transfer after reset
      xfer(12'h3FC, 1'b0, 32'h0, lat, rd, e);
      chk("post_rst_latency", 64'(lat), 64'd3);
      chk("post_rst_prdata",  rd,       32'hCAFE0003);

      // back-to-back transfers: one pulse each
      p0 = n_pulse;
      xfer(12'h200, 1'b0, 32'h0, lat, rd, e);
      chk("b2b_first_pulses", 64'(n_pulse - p0), 64'd1);
      xfer(12'h100, 1'b1, 32'hDEADBEEF, lat, rd, e);
      chk("b2b_second_pulses", 64'(n_pulse - p0), 64'd2);
      chk("b2b_second_perr",   e, 1'b1);
      tick(); tick();
      chk("b2b_total_pulses", 64'(n_pulse - p0), 64'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
